// File: rtl/if_queue.sv
// if_queue: instruction queue between ifetch1 and decode.
//   Circular buffer of DEPTH {pc, inst} entries. The oldest entry is presented to
//   decode, which consumes it with a valid/stall handshake. stall_o rises SKID
//   entries before full, so fetches already in flight still have a free slot.
//   flush_i (branch taken) empties the queue. ovf_o is a sticky error flag that
//   only reset clears.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   v_i      ifetch1 output valid
//   pc_i     address of inst_i
//   inst_i   fetched instruction
//   flush_i  branch taken: drop every entry and the fetch in this cycle
//   stall_o  back-pressure to ifetch1
//   stall_i  decode cannot accept this cycle
//   v_o      head entry valid
//   pc_o     head entry pc (0 when empty)
//   inst_o   head entry instruction (0 when empty)
//   ovf_o    sticky overflow
module if_queue #(
    parameter int ADDR  = 32,
    parameter int INST  = 32,
    parameter int DEPTH = 4,
    parameter int SKID  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    input  logic [ADDR-1:0] pc_i,
    input  logic [INST-1:0] inst_i,
    input  logic            flush_i,
    output logic            stall_o,
    input  logic            stall_i,
    output logic            v_o,
    output logic [ADDR-1:0] pc_o,
    output logic [INST-1:0] inst_o,
    output logic            ovf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL  = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_STALL = (PW+1)'(DEPTH - SKID);

    logic [ADDR-1:0] pc_mem   [DEPTH];
    logic [INST-1:0] inst_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            full;
    logic            push;
    logic            pop;

    assign full = (count == CNT_FULL);
    assign v_o  = (count != '0);

    // A pop in the same cycle frees the head slot, so a full queue can still accept.
    assign pop  = v_o & ~stall_i & ~flush_i;
    assign push = v_i & ~flush_i & (~full | pop);

    assign stall_o = (count >= CNT_STALL);
    assign pc_o    = v_o ? pc_mem[rd_ptr]   : '0;
    assign inst_o  = v_o ? inst_mem[rd_ptr] : '0;

    // Storage is not reset; v_o masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pc_i;
            inst_mem[wr_ptr] <= inst_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (v_i && full && !pop) ovf_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_queue.sv
module tb_if_queue;

    localparam logic [31:0] IK = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        flush_i;
    logic        stall_o;
    logic        stall_i;
    logic        v_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        ovf_o;

    int tests  = 0;
    int failed = 0;

    if_queue #(.ADDR(32), .INST(32), .DEPTH(4), .SKID(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .v_i     (v_i),
        .pc_i    (pc_i),
        .inst_i  (inst_i),
        .flush_i (flush_i),
        .stall_o (stall_o),
        .stall_i (stall_i),
        .v_o     (v_o),
        .pc_o    (pc_o),
        .inst_o  (inst_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    // One row: inputs applied before an edge, expected outputs after that edge.
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        fl;
        logic        st;
        logic        ev;
        logic [31:0] epc;
        logic        es;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic es, input logic eo);
        chk({tag, " v_o"},     {31'd0, v_o},     {31'd0, ev});
        chk({tag, " pc_o"},    pc_o,             ev ? epc : 32'd0);
        chk({tag, " inst_o"},  inst_o,           ev ? (epc ^ IK) : 32'd0);
        chk({tag, " stall_o"}, {31'd0, stall_o}, {31'd0, es});
        chk({tag, " ovf_o"},   {31'd0, ovf_o},   {31'd0, eo});
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic st);
        v_i     = v;
        pc_i    = pc;
        inst_i  = pc ^ IK;
        flush_i = fl;
        stall_i = st;
    endtask

    task automatic add(input logic v, input logic [31:0] pc, input logic fl, input logic st,
                       input logic ev, input logic [31:0] epc, input logic es, input logic eo);
        vec_t r;
        r.v = v; r.pc = pc; r.fl = fl; r.st = st;
        r.ev = ev; r.epc = epc; r.es = es; r.eo = eo;
        vecs.push_back(r);
    endtask

    initial begin
        //    v  pc  fl st   ev epc es eo
        // streaming, one-cycle latency, count stays 1
        add(1,  0, 0, 0,   1,  0, 0, 0);
        add(1,  1, 0, 0,   1,  1, 0, 0);
        add(1,  2, 0, 0,   1,  2, 0, 0);
        add(0,  0, 0, 0,   0,  0, 0, 0);
        // fill while decode stalls; stall_o at count 3
        add(1, 10, 0, 1,   1, 10, 0, 0);
        add(1, 11, 0, 1,   1, 10, 0, 0);
        add(1, 12, 0, 1,   1, 10, 1, 0);
        add(1, 13, 0, 1,   1, 10, 1, 0);
        // full with push+pop: head advances, no overflow
        add(1, 14, 0, 0,   1, 11, 1, 0);
        add(0,  0, 0, 0,   1, 12, 1, 0);
        add(0,  0, 0, 0,   1, 13, 0, 0);
        add(0,  0, 0, 0,   1, 14, 0, 0);
        add(0,  0, 0, 0,   0,  0, 0, 0);
        // stall_i on empty queue
        add(0,  0, 0, 1,   0,  0, 0, 0);
        // flush with count 2 and v_i high
        add(1, 20, 0, 1,   1, 20, 0, 0);
        add(1, 21, 0, 1,   1, 20, 0, 0);
        add(1, 22, 1, 1,   0,  0, 0, 0);
        add(1,  2, 0, 1,   1,  2, 0, 0);
        add(0,  0, 0, 0,   0,  0, 0, 0);
        // overflow: full, stalled, another fetch
        add(1, 30, 0, 1,   1, 30, 0, 0);
        add(1, 31, 0, 1,   1, 30, 0, 0);
        add(1, 32, 0, 1,   1, 30, 1, 0);
        add(1, 33, 0, 1,   1, 30, 1, 0);
        add(1, 34, 0, 1,   1, 30, 1, 1);
        add(0,  0, 0, 1,   1, 30, 1, 1);
        add(0,  0, 0, 0,   1, 31, 1, 1);
        add(0,  0, 0, 0,   1, 32, 0, 1);
        add(0,  0, 0, 0,   1, 33, 0, 1);
        add(0,  0, 0, 0,   0,  0, 0, 1);
        // flush does not clear ovf_o
        add(1, 50, 0, 1,   1, 50, 0, 1);
        add(0,  0, 1, 0,   0,  0, 0, 1);

        rst = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].pc, vecs[i].fl, vecs[i].st);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].es, vecs[i].eo);
        end

        // mid-run asynchronous reset with count 3 (ovf_o still set from above)
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 32'(60 + i), 0, 1);
            @(posedge clk);
        end
        #1;
        chk_all("pre_rst", 1, 60, 1, 1);
        #1;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 70, 0, 0);
        rst = 1'b1;
        #1;
        chk_all("rst_release", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("first_push", 1, 70, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("drain", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
